uart_tx_scheduler: RTL

Round-robin scheduler that shares one UART transmitter between `NREQ` byte-stream requesters. It grants the transmitter to one requester for a whole packet, which is terminated by `req_last`, and optionally prefixes the packet with a header byte carrying the requester ID. It sequences the transmitter's start/ack/done handshake and enforces an idle gap between packets. It sits between the producer blocks (ALU result formatter, debug/status sources) and the Transmitter.

---
 rtl/uart_tx_scheduler.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte streams, one packet per grant.
// Grant one cycle after request; requester held by req_ready pops, transmitter paced by tx_ack/tx_done.
module uart_tx_scheduler #(
  parameter int NREQ       = 4,
  parameter int DBIT       = 8,
  parameter int HDR_EN     = 1,
  parameter int GAP_CYCLES = 16,
  parameter int STALL_MAX  = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*DBIT-1:0] req_data,
  input  logic [NREQ-1:0]      req_last,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      grant,
  output logic                 tx_start,
  output logic [DBIT-1:0]      tx_din,
  input  logic                 tx_ack,
  input  logic                 tx_done,
  output logic                 busy,
  output logic                 abort
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW = $clog2(STALL_MAX + 1);
  localparam logic [7:0]    GAP_LAST   = (GAP_CYCLES == 0) ? 8'd0 : 8'(GAP_CYCLES - 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MAX - 1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_SEND, S_WAIT, S_GAP} state_t;

  state_t          state, state_d;
  logic [IW-1:0]   ptr, ptr_d, gidx, gidx_d;
  logic [NREQ-1:0] grant_d, ready_d;
  logic            start_d, abort_d, busy_d;
  logic            last_r, last_d, hdr_phase, hdr_phase_d;
  logic [DBIT-1:0] din_d, hdr_byte, sel_dat;
  logic [7:0]      gap_cnt, gap_d;
  logic [SW-1:0]   stall_cnt, stall_d;
  logic            pick_vld, sel_vld, sel_last;
  logic [IW-1:0]   pick_idx;

  function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] p, input int k);
    int j;
    j = int'(p) + k;
    if (j >= NREQ) j = j - NREQ;
    return IW'(j);
  endfunction

  // First valid requester at or after ptr, wrapping.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (!pick_vld && req_valid[rr_idx(ptr, k)]) begin
        pick_vld = 1'b1;
        pick_idx = rr_idx(ptr, k);
      end
    end
  end

  always_comb begin
    sel_vld  = req_valid[gidx];
    sel_last = req_last[gidx];
    sel_dat  = req_data[gidx*DBIT +: DBIT];
    hdr_byte = '0;
    hdr_byte[DBIT-1] = 1'b1;
    hdr_byte[IW-1:0] = gidx;
  end

  always_comb begin
    state_d     = state;
    ptr_d       = ptr;
    gidx_d      = gidx;
    grant_d     = grant;
    ready_d     = '0;
    start_d     = tx_start;
    abort_d     = 1'b0;
    din_d       = tx_din;
    last_d      = last_r;
    hdr_phase_d = hdr_phase;
    gap_d       = gap_cnt;
    stall_d     = stall_cnt;
    case (state)
      S_IDLE: begin
        if (pick_vld) begin
          gidx_d          = pick_idx;
          grant_d         = '0;
          grant_d[pick_idx] = 1'b1;
          stall_d         = '0;
          hdr_phase_d     = 1'b0;
          state_d         = (HDR_EN != 0) ? S_HDR : S_SEND;
        end
      end
      S_HDR: begin
        if (!tx_start) begin
          din_d   = hdr_byte;
          start_d = 1'b1;
        end else if (tx_ack) begin
          start_d     = 1'b0;
          hdr_phase_d = 1'b1;
          state_d     = S_WAIT;
        end
      end
      S_SEND: begin
        if (tx_start) begin
          if (tx_ack) begin
            start_d = 1'b0;
            ready_d = grant;
            state_d = S_WAIT;
          end
        end else if (sel_vld) begin
          din_d   = sel_dat;
          last_d  = sel_last;
          start_d = 1'b1;
          stall_d = '0;
        end else if (stall_cnt >= STALL_LAST) begin
          abort_d = 1'b1;
          state_d = S_GAP;
          grant_d = '0;
          gap_d   = '0;
          ptr_d   = (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
        end else begin
          stall_d = stall_cnt + 1'b1;
        end
      end
      S_WAIT: begin
        if (tx_done) begin
          if (hdr_phase) begin
            hdr_phase_d = 1'b0;
            state_d     = S_SEND;
          end else if (last_r) begin
            state_d = S_GAP;
            grant_d = '0;
            gap_d   = '0;
            ptr_d   = (gidx == IW'(NREQ - 1)) ? '0 : gidx + 1'b1;
          end else begin
            state_d = S_SEND;
          end
        end
      end
      S_GAP: begin
        if (gap_cnt >= GAP_LAST) state_d = S_IDLE;
        else gap_d = gap_cnt + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      ptr       <= '0;
      gidx      <= '0;
      grant     <= '0;
      req_ready <= '0;
      tx_start  <= 1'b0;
      tx_din    <= '0;
      abort     <= 1'b0;
      busy      <= 1'b0;
      last_r    <= 1'b0;
      hdr_phase <= 1'b0;
      gap_cnt   <= '0;
      stall_cnt <= '0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      gidx      <= gidx_d;
      grant     <= grant_d;
      req_ready <= ready_d;
      tx_start  <= start_d;
      tx_din    <= din_d;
      abort     <= abort_d;
      busy      <= busy_d;
      last_r    <= last_d;
      hdr_phase <= hdr_phase_d;
      gap_cnt   <= gap_d;
      stall_cnt <= stall_d;
    end
  end

endmodule
